mbist_march_ctrl: RTL and testbench
===================================

Name: mbist_march_ctrl

Overview:
- March C- BIST engine that sits directly upstream of the single-port test memory.
- Drives the memory's write_read/address/wdata and checks its rdata.
- Sequences the six March C- elements over addresses 0..CAPACITY and compensates for the memory's 1-cycle write-data lag and 2-cycle read latency.
- Reports pass/fail, a saturating fail count and the first failing address/element.

Parameters:
- DATA_WIDTH, 8, memory word width.
- ADDR_WIDTH, 4, memory address width.
- CAPACITY, 15, highest memory address; the sweep covers 0..CAPACITY inclusive.
- CNT_WIDTH, 8, width of fail_count.

Ports:
- clk  input  1  rising-edge clock shared with the memory.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that begins a test; ignored while busy.
- mem_write_read  output  1  1 = write, 0 = read; to memory write_read.
- mem_address  output  ADDR_WIDTH  to memory address.
- mem_wdata  output  DATA_WIDTH  to memory wdata.
- mem_rdata  input  DATA_WIDTH  from memory rdata.
- busy  output  1  high from the cycle after start until done rises.
- done  output  1  level; high once the test and compare drain are complete; cleared by the next accepted start.
- fail  output  1  sticky mismatch flag.
- fail_count  output  CNT_WIDTH  number of mismatching reads, saturating at all-ones.
- fail_addr  output  ADDR_WIDTH  address of the first mismatch.
- fail_element  output  3  March element index (0..5) of the first mismatch.

Behaviour:
- Reset: all outputs 0. State = IDLE.
- All memory-side outputs are registered.
- Memory timing contract:
  - A write issued in cycle t stores the mem_wdata value driven in cycle t-1.
  - A read issued in cycle t returns data on mem_rdata in cycle t+2.
- Backgrounds: B0 = all zeros; B1 = all ones (DATA_WIDTH wide).
- Elements:
  - M0 up(w0)
  - M1 up(r0,w1)
  - M2 up(r1,w0)
  - M3 down(r0,w1)
  - M4 down(r1,w0)
  - M5 down(r0)
- Address order: "up" sweeps 0..CAPACITY; "down" sweeps CAPACITY..0.
- States:
  - IDLE: write_read=0, address=0, wdata=0. Accepted start clears done, fail, fail_count, fail_addr, fail_element, then goes to SETUP.
  - SETUP: 1 cycle; read with no compare; address 0; wdata=B0. Goes to M0.
  - M0: 1 cycle per address, write.
  - M1-M4: 2 cycles per address, read then write at the same address.
  - M5: 1 cycle per address, read.
  - DRAIN: 2 cycles, write_read=0, no compare. Then done=1, busy=0, back to IDLE.
- Element transitions: the last address of an element is followed immediately by the first address of the next element, with no gap cycle.
- Write-data lead: mem_wdata equals the current element's write background from the element's first cycle onward.
  - Because of this lead, the read cycle of each address already presents the write value.
  - SETUP supplies the lead for M0.
  - M5 holds wdata=B0.
- Compare pipeline: every read in M1-M5 pushes {expected background, address, element} into a 2-stage pipe. Two cycles later mem_rdata is compared against the expected value.
- On mismatch:
  - fail <= 1.
  - fail_count increments, saturating at all-ones.
  - fail_addr and fail_element are captured only when fail was 0 before this mismatch.
- Total run: 1 + 10*(CAPACITY+1) cycles of memory operations, plus 2 DRAIN cycles. Default run is 163 cycles.
- start while busy is ignored, with no state change.
- start in the same cycle that done rises is ignored; start must arrive from IDLE.
- rst_n low mid-run forces everything to reset values immediately, including the compare pipe, so no compare occurs after reset.
- Address counters wrap only at element boundaries. No address outside 0..CAPACITY is ever driven.
- fail_count arithmetic is CNT_WIDTH unsigned with saturation, never wrap.

Test Plan:
- Fault-free memory model with the stated timing, start pulse → busy for 163 cycles, then done=1, fail=0, fail_count=0. Monitor confirms the op sequence (w,0) ... (r,15),(w,15) ... (r,0).
- Bit1 stuck-at-0 at address 5 → fail=1, fail_count=2 (M2 and M4 r1), fail_addr=5, fail_element=2, done after 163 cycles.
- Bit7 stuck-at-1 at address 0 → fail_count=3 (M1, M3, M5), fail_addr=0, fail_element=1.
- Write-lag check: model ignores wdata timing and writes the current-cycle wdata → must produce mismatches. Correct model → zero mismatches; proves wdata leads by one cycle.
- start pulsed at cycle 40 of a run → ignored, total duration unchanged. rst_n pulled low at cycle 80 → all outputs 0 next cycle. New start then runs a full clean 163-cycle test.
- CNT_WIDTH=2 with every word stuck-at-0 → fail_count saturates at 3; fail_addr=0, fail_element=2.

Source files
------------

// File: rtl/mbist_march_ctrl.sv
// mbist_march_ctrl: March C- BIST engine driving a single-port memory with 1-cycle wdata lag and 2-cycle read latency.
module mbist_march_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int CAPACITY   = 15,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  mem_write_read,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [CNT_WIDTH-1:0]  fail_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_element
);
  typedef enum logic [1:0] {IDLE, SETUP, MARCH, DRAIN} state_t;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(CAPACITY);
  state_t st, st_n;
  logic [2:0] elem, elem_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [DATA_WIDTH-1:0] wdata_n;
  logic wr_n, drain_cnt, drain_n, done_n, down, adv, last_addr, push, mis;
  logic p1_v, p2_v, p1_bg, p2_bg;
  logic [ADDR_WIDTH-1:0] p1_addr, p2_addr;
  logic [2:0] p1_elem, p2_elem;
  assign busy = st != IDLE;
  assign down = elem >= 3'd3;
  assign adv = elem == 3'd0 || elem == 3'd5 || mem_write_read;
  assign last_addr = down ? mem_address == '0 : mem_address == LAST;
  assign push = st == MARCH && elem != 3'd0 && !mem_write_read;
  assign mis = p2_v && mem_rdata != {DATA_WIDTH{p2_bg}};
  always_comb begin
    st_n = st;
    elem_n = elem;
    addr_n = mem_address;
    wr_n = mem_write_read;
    wdata_n = mem_wdata;
    drain_n = drain_cnt;
    done_n = done;
    case (st)
      IDLE: if (start) begin
        st_n = SETUP;
        done_n = 1'b0;
      end
      SETUP: begin
        st_n = MARCH;
        elem_n = 3'd0;
        wr_n = 1'b1;
      end
      MARCH: if (!adv) wr_n = 1'b1;
      else if (!last_addr) begin
        addr_n = down ? mem_address - ADDR_WIDTH'(1) : mem_address + ADDR_WIDTH'(1);
        wr_n = elem == 3'd0;
      end else if (elem == 3'd5) begin
        st_n = DRAIN;
        drain_n = 1'b0;
        wr_n = 1'b0;
        addr_n = '0;
        wdata_n = '0;
      end else begin
        elem_n = elem + 3'd1;
        addr_n = elem_n >= 3'd3 ? LAST : '0;
        wr_n = 1'b0;
        wdata_n = (elem_n == 3'd1 || elem_n == 3'd3) ? '1 : '0;
      end
      DRAIN: begin
        drain_n = !drain_cnt;
        if (drain_cnt) begin
          st_n = IDLE;
          done_n = 1'b1;
        end
      end
      default: st_n = IDLE;
    endcase
  end
  // Reads are checked two cycles later against the background captured at issue.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= IDLE;
      elem <= '0;
      drain_cnt <= 1'b0;
      mem_write_read <= 1'b0;
      mem_address <= '0;
      mem_wdata <= '0;
      done <= 1'b0;
      fail <= 1'b0;
      fail_count <= '0;
      fail_addr <= '0;
      fail_element <= '0;
      {p1_v, p1_bg, p1_addr, p1_elem} <= '0;
      {p2_v, p2_bg, p2_addr, p2_elem} <= '0;
    end else begin
      st <= st_n;
      elem <= elem_n;
      drain_cnt <= drain_n;
      mem_write_read <= wr_n;
      mem_address <= addr_n;
      mem_wdata <= wdata_n;
      done <= done_n;
      {p1_v, p1_bg, p1_addr, p1_elem} <= {push, elem == 3'd2 || elem == 3'd4, mem_address, elem};
      {p2_v, p2_bg, p2_addr, p2_elem} <= {p1_v, p1_bg, p1_addr, p1_elem};
      if (st == IDLE && start) begin
        fail <= 1'b0;
        fail_count <= '0;
        fail_addr <= '0;
        fail_element <= '0;
      end else if (mis) begin
        fail <= 1'b1;
        if (fail_count != '1) fail_count <= fail_count + CNT_WIDTH'(1);
        if (!fail) begin
          fail_addr <= p2_addr;
          fail_element <= p2_elem;
        end
      end
    end
endmodule

// File: tb/tb_mbist_march_ctrl.sv
// tb_mbist_march_ctrl: March C- engine against a behavioural memory with stuck-at faults and a queue-based op reference.
module tb_mbist_march_ctrl;
  localparam int DW = 8, AW = 4, CAP = 15, CW = 8, N = CAP + 1;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic wr, busy, done, fail, s_wr, s_busy, s_done, s_fail;
  logic [AW-1:0] addr, faddr, s_addr, s_faddr;
  logic [DW-1:0] wdata, rdata, s_wdata;
  logic [DW-1:0] s_rdata = '0;
  logic [CW-1:0] fcnt;
  logic [1:0] s_cnt;
  logic [2:0] felem, s_felem;
  logic [DW-1:0] mem [N];
  logic [DW-1:0] sa0 [N];
  logic [DW-1:0] sa1 [N];
  logic [DW-1:0] wd_prev, r1, r2;
  typedef struct {logic w; logic [AW-1:0] a; logic [DW-1:0] d;} op_t;
  typedef struct {int a; logic [DW-1:0] s0; logic [DW-1:0] s1; int cnt; int fa; int fe;} vec_t;
  op_t ops[$];
  vec_t tbl[4];
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  mbist_march_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CAPACITY(CAP), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mem_write_read(wr), .mem_address(addr),
    .mem_wdata(wdata), .mem_rdata(rdata), .busy(busy), .done(done), .fail(fail),
    .fail_count(fcnt), .fail_addr(faddr), .fail_element(felem));

  // Every word stuck-at-0: reads always return zero.
  mbist_march_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CAPACITY(CAP), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .mem_write_read(s_wr), .mem_address(s_addr),
    .mem_wdata(s_wdata), .mem_rdata(s_rdata), .busy(s_busy), .done(s_done), .fail(s_fail),
    .fail_count(s_cnt), .fail_addr(s_faddr), .fail_element(s_felem));

  always @(posedge clk) begin
    wd_prev <= wdata;
    if (wr) mem[addr] <= wd_prev;
    r1 <= (mem[addr] & ~sa0[addr]) | sa1[addr];
    r2 <= r1;
  end
  assign rdata = r2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_faults();
    for (int i = 0; i < N; i++) begin
      sa0[i] = '0;
      sa1[i] = '0;
    end
  endtask

  task automatic build_ops();
    op_t o;
    ops.delete();
    o = '{1'b0, '0, '0};
    ops.push_back(o);
    for (int e = 0; e < 6; e++)
      for (int k = 0; k < N; k++) begin
        o.a = AW'(e < 3 ? k : CAP - k);
        o.d = (e == 1 || e == 3) ? '1 : '0;
        o.w = 1'b0;
        if (e > 0) ops.push_back(o);
        o.w = 1'b1;
        if (e < 5) ops.push_back(o);
      end
  endtask

  task automatic model(output int c, output int fa, output int fe);
    logic [DW-1:0] rb, act;
    int a;
    c = 0; fa = 0; fe = 0;
    for (int e = 1; e < 6; e++)
      for (int k = 0; k < N; k++) begin
        a = e < 3 ? k : CAP - k;
        rb = (e == 2 || e == 4) ? '1 : '0;
        act = (rb & ~sa0[a]) | sa1[a];
        if (act != rb) begin
          if (c == 0) begin fa = a; fe = e; end
          if (c < (1 << CW) - 1) c++;
        end
      end
  endtask

  task automatic run(input bit mid_start, input bit late_start, input int ecnt, input int eaddr, input int eelem);
    int n;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("done_cleared", done, 0);
    n = 0;
    while (busy && n < 400) begin
      chk("op_wr", wr, n < ops.size() ? ops[n].w : 1'b0);
      if (n < ops.size()) begin
        chk("op_addr", addr, ops[n].a);
        chk("op_wdata", wdata, ops[n].d);
      end
      start = (mid_start && n == 40) || (late_start && n == 162);
      n++;
      @(negedge clk);
    end
    start = 1'b0;
    chk("run_len", n, 163);
    chk("done", done, 1);
    chk("fail", fail, ecnt != 0);
    chk("fail_count", fcnt, ecnt);
    chk("fail_addr", faddr, eaddr);
    chk("fail_element", felem, eelem);
    chk("sat_count", s_cnt, 3);
    chk("sat_addr", s_faddr, 0);
    chk("sat_element", s_felem, 2);
    if (late_start) begin
      repeat (2) @(negedge clk);
      chk("late_start_busy", busy, 0);
      chk("late_start_done", done, 1);
    end
  endtask

  initial begin
    int c, fa, fe, a;
    for (int i = 0; i < N; i++) mem[i] = '0;
    clear_faults();
    build_ops();
    tbl[0] = '{0, 8'h00, 8'h00, 0, 0, 0};
    tbl[1] = '{5, 8'h02, 8'h00, 2, 5, 2};
    tbl[2] = '{0, 8'h00, 8'h80, 3, 0, 1};
    tbl[3] = '{15, 8'hff, 8'h00, 2, 15, 2};
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fail", fail, 0);
    chk("rst_mem", {wr, addr, wdata}, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      clear_faults();
      sa0[tbl[i].a] = tbl[i].s0;
      sa1[tbl[i].a] = tbl[i].s1;
      run(i == 1, i == 2, tbl[i].cnt, tbl[i].fa, tbl[i].fe);
    end
    for (int r = 0; r < 5; r++) begin
      clear_faults();
      a = $urandom_range(0, CAP);
      sa0[a] = DW'($urandom);
      sa1[a] = DW'($urandom) & ~sa0[a];
      a = $urandom_range(0, CAP);
      sa0[a] = sa0[a] | DW'(1 << $urandom_range(0, DW - 1));
      model(c, fa, fe);
      run(1'b0, 1'b0, c, fa, fe);
    end
    clear_faults();
    sa0[5] = 8'h02;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (80) @(negedge clk);
    chk("pre_reset_fail", fail, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_flags", {done, fail, fcnt, faddr, felem}, 0);
    chk("mid_rst_mem", {wr, addr, wdata}, 0);
    chk("mid_rst_sat", {s_busy, s_fail, s_cnt}, 0);
    @(negedge clk) rst_n = 1'b1;
    clear_faults();
    run(1'b0, 1'b0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
